// File: rtl/rx_payload_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_payload_seq_if
// Purpose  : Bundles the receive word stream, the checker-facing payload bus,
//            the per-frame result and the statistics bus of rx_payload_seq.
// Modports : slave  - the sequencer (consumes rx_*, payload_esum, stats_clr)
//            master - the environment driving frames and hosting the checker
// Signals  : rx_valid/rx_ready/rx_sop/rx_eop/rx_data   word stream
//            payload_pre/seed/type/valid/data/esum     checker interface
//            result_valid/esum/words                   per-frame result
//            stats_clr, frame_cnt, err_frame_cnt,
//            err_bit_total, abort_cnt                  host statistics
// Revision : 1.0 - initial release
// ============================================================================
interface rx_payload_seq_if;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_sop;
    logic        rx_eop;
    logic [31:0] rx_data;
    logic        payload_pre;
    logic [31:0] payload_seed;
    logic [3:0]  payload_type;
    logic        payload_valid;
    logic [31:0] payload_data;
    logic [31:0] payload_esum;
    logic        result_valid;
    logic [31:0] result_esum;
    logic [15:0] result_words;
    logic        stats_clr;
    logic [31:0] frame_cnt;
    logic [31:0] err_frame_cnt;
    logic [31:0] err_bit_total;
    logic [31:0] abort_cnt;

    modport slave (
        input  rx_valid, rx_sop, rx_eop, rx_data, payload_esum, stats_clr,
        output rx_ready, payload_pre, payload_seed, payload_type,
               payload_valid, payload_data, result_valid, result_esum,
               result_words, frame_cnt, err_frame_cnt, err_bit_total, abort_cnt
    );

    modport master (
        output rx_valid, rx_sop, rx_eop, rx_data, payload_esum, stats_clr,
        input  rx_ready, payload_pre, payload_seed, payload_type,
               payload_valid, payload_data, result_valid, result_esum,
               result_words, frame_cnt, err_frame_cnt, err_bit_total, abort_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rx_payload_seq.sv
`default_nettype none
// ============================================================================
// Module   : rx_payload_seq
// Purpose  : Per-frame sequencer for the receive payload checker. Extracts
//            seed/type from the frame header, pulses the checker preload,
//            forwards payload words one cycle delayed, latches the settled
//            checker error sum as the frame result and keeps statistics.
// Ports    : clk    - clock
//            rst_n  - asynchronous active-low reset
//            bus    - rx_payload_seq_if.slave (stream, checker, result, stats)
// Options  : RX_PAYLOAD_TIMEOUT_EN - abort a frame after TIMEOUT_CYC idle
//            cycles in HDR/PLD; undefined means wait for eop indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module rx_payload_seq #(
    parameter int HDR_WORDS   = 4,
    parameter int SEED_WORD   = 2,
    parameter int TYPE_WORD   = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rx_payload_seq_if.slave    bus
);

    localparam int IDX_W = $clog2(HDR_WORDS) + 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(HDR_WORDS - 1);
    localparam logic [IDX_W-1:0] c_seed_idx = IDX_W'(SEED_WORD);
    localparam logic [IDX_W-1:0] c_type_idx = IDX_W'(TYPE_WORD);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_PLD   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             drain_q, drain_d;
    logic             rdy_q, rdy_d;
    logic             pre_q, pre_d;
    logic [31:0]      seed_q, seed_d;
    logic [3:0]       type_q, type_d;
    logic             pv_q, pv_d;
    logic [31:0]      pd_q, pd_d;
    logic [15:0]      wc_q, wc_d;
    logic             res_v_q, res_v_d;
    logic [31:0]      res_esum_q, res_esum_d;
    logic [15:0]      res_words_q, res_words_d;
    logic [31:0]      frame_cnt_q, errf_cnt_q, errb_tot_q, abort_cnt_q;

    logic             accept;
    logic             take_hdr;
    logic [IDX_W-1:0] hdr_idx;
    logic             abort_inc;
    logic             done_upd;
    logic [32:0]      bits_sum;

    assign accept  = bus.rx_valid & rdy_q;
    // sop always restarts the header at index 0, whatever the current state
    assign hdr_idx = bus.rx_sop ? '0 : idx_q;
    assign take_hdr = accept & (((state_q == S_IDLE) & bus.rx_sop) |
                                 (state_q == S_HDR) |
                                ((state_q == S_PLD) & bus.rx_sop));
    assign bits_sum = {1'b0, errb_tot_q} + {1'b0, res_esum_q};

`ifdef RX_PAYLOAD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_q, to_d;
    logic            to_hit;
    assign to_hit = ((state_q == S_HDR) || (state_q == S_PLD)) && !accept &&
                    (to_q == TO_W'(TIMEOUT_CYC - 1));
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        drain_d     = drain_q;
        seed_d      = seed_q;
        type_d      = type_q;
        pre_d       = 1'b0;
        pv_d        = 1'b0;
        pd_d        = pd_q;
        wc_d        = wc_q;
        res_v_d     = 1'b0;
        res_esum_d  = res_esum_q;
        res_words_d = res_words_q;
        abort_inc   = 1'b0;
        done_upd    = 1'b0;

        if (take_hdr) begin
            if (hdr_idx == c_seed_idx) seed_d = bus.rx_data;
            if (hdr_idx == c_type_idx) type_d = bus.rx_data[3:0];
            idx_d = hdr_idx + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept && bus.rx_sop) begin
                    if (bus.rx_eop) abort_inc = 1'b1;   // runt frame
                    else            state_d   = S_HDR;
                end
            end
            S_HDR: begin
                if (accept) begin
                    // a restart by sop and an early eop count as one abort
                    abort_inc = bus.rx_sop |
                                (bus.rx_eop & (hdr_idx != c_last_idx));
                    if (hdr_idx == c_last_idx) begin
                        pre_d   = 1'b1;
                        wc_d    = '0;
                        drain_d = 1'b0;
                        state_d = bus.rx_eop ? S_DRAIN : S_PLD;
                    end else if (bus.rx_eop) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_PLD: begin
                if (accept) begin
                    if (bus.rx_sop) begin
                        abort_inc = 1'b1;
                        state_d   = bus.rx_eop ? S_IDLE : S_HDR;
                    end else begin
                        pv_d = 1'b1;
                        pd_d = bus.rx_data;
                        wc_d = (wc_q == 16'hFFFF) ? wc_q : wc_q + 16'd1;
                        if (bus.rx_eop) begin
                            drain_d = 1'b0;
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                // second drain cycle: the checker sum now reflects the last word
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d     = S_DONE;
                    res_v_d     = 1'b1;
                    res_esum_d  = bus.payload_esum;
                    res_words_d = wc_q;
                end
            end
            S_DONE: begin
                done_upd = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef RX_PAYLOAD_TIMEOUT_EN
        to_d = (((state_q == S_HDR) || (state_q == S_PLD)) && !accept) ?
               to_q + 1'b1 : '0;
        if (to_hit) begin
            abort_inc = 1'b1;
            pv_d      = 1'b0;
            pre_d     = 1'b0;
            state_d   = S_IDLE;
            to_d      = '0;
        end
`endif

        rdy_d = (state_d == S_IDLE) || (state_d == S_HDR) || (state_d == S_PLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            drain_q     <= 1'b0;
            rdy_q       <= 1'b0;
            pre_q       <= 1'b0;
            seed_q      <= '0;
            type_q      <= '0;
            pv_q        <= 1'b0;
            pd_q        <= '0;
            wc_q        <= '0;
            res_v_q     <= 1'b0;
            res_esum_q  <= '0;
            res_words_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            drain_q     <= drain_d;
            rdy_q       <= rdy_d;
            pre_q       <= pre_d;
            seed_q      <= seed_d;
            type_q      <= type_d;
            pv_q        <= pv_d;
            pd_q        <= pd_d;
            wc_q        <= wc_d;
            res_v_q     <= res_v_d;
            res_esum_q  <= res_esum_d;
            res_words_q <= res_words_d;
        end
    end

`ifdef RX_PAYLOAD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_q <= '0;
        else        to_q <= to_d;
    end
`endif

    // Statistics: a clear in the DONE cycle wins over that frame's update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            errf_cnt_q  <= '0;
            errb_tot_q  <= '0;
            abort_cnt_q <= '0;
        end else if (bus.stats_clr) begin
            frame_cnt_q <= '0;
            errf_cnt_q  <= '0;
            errb_tot_q  <= '0;
            abort_cnt_q <= '0;
        end else begin
            if (abort_inc) abort_cnt_q <= abort_cnt_q + 32'd1;
            if (done_upd) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
                if (res_esum_q != 32'd0) errf_cnt_q <= errf_cnt_q + 32'd1;
                errb_tot_q <= bits_sum[32] ? 32'hFFFF_FFFF : bits_sum[31:0];
            end
        end
    end

    assign bus.rx_ready      = rdy_q;
    assign bus.payload_pre   = pre_q;
    assign bus.payload_seed  = seed_q;
    assign bus.payload_type  = type_q;
    assign bus.payload_valid = pv_q;
    assign bus.payload_data  = pd_q;
    assign bus.result_valid  = res_v_q;
    assign bus.result_esum   = res_esum_q;
    assign bus.result_words  = res_words_q;
    assign bus.frame_cnt     = frame_cnt_q;
    assign bus.err_frame_cnt = errf_cnt_q;
    assign bus.err_bit_total = errb_tot_q;
    assign bus.abort_cnt     = abort_cnt_q;

endmodule
`default_nettype wire
